alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Two-requester arbiter that time-shares one 32-bit combinational alu (A, B, ALUOp[2:0] -> C) with valid/ready handshakes on both sides. Each requester presents an operand pair and opcode. The block grants one requester per cycle using round-robin priority, drives the shared alu, and captures C into a single-entry response register tagged with the requester id. It sits between the datapath issue logic and the alu, so the alu has exactly one owner per cycle.

Parameters:
WIDTH, 32, operand/result width; fixed to 32 to match alu
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  3  requester 0 ALUOp
req0_ready  output  1  requester 0 operation accepted this cycle
req1_valid  input  1  requester 1 has an operation
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_op  input  3  requester 1 ALUOp
req1_ready  output  1  requester 1 operation accepted this cycle
rsp_valid  output  1  response register holds a result
rsp_data  output  WIDTH  captured alu result C
rsp_id  output  1  requester that owns rsp_data
rsp_ready  input  1  consumer takes the response this cycle
done_cnt  output  CNT_W  count of responses consumed

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, done_cnt=0, prio=0. An in-flight result is discarded. req*_ready are combinational and evaluate to 0 while rsp_valid=0 and both valid are low.
- Response register is a 2-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = (state==EMPTY) | rsp_ready. In FULL with rsp_ready=1, the register is consumed and refilled in the same cycle at full throughput.
- Grant, combinational:
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant prio (prio=0 favours req0, prio=1 favours req1).
  - reqN_ready = can_accept & grantN. At most one ready is high per cycle.
- Mux: the granted requester's a/b/op drive the alu instance. With no grant, the alu inputs are driven to 0.
- Accept (any reqN_valid & reqN_ready) at edge N:
  - rsp_data <= C, rsp_id <= N, rsp_valid <= 1. Latency is 1 cycle, so the result is visible the cycle after the accept.
  - prio <= ~N. The pointer updates on every accept, including uncontested ones.
- Consume without refill (FULL, rsp_ready=1, no accept): rsp_valid <= 0. rsp_data and rsp_id hold their last value.
- done_cnt increments on every rsp_valid & rsp_ready and wraps modulo 2^CNT_W.
- FULL with rsp_ready=0: both readys are 0 and rsp_data/rsp_id are stable. Requesters must hold valid and payload stable until ready. reqN_valid must not depend on reqN_ready.
- rsp_ready while EMPTY is ignored; done_cnt is unchanged.
- ALUOp is passed through opaque; the opcode semantics belong to alu.

Decomposition:
- Shared package: WIDTH, the 3-bit ALUOp encodings (ADD=000, SUB=001, AND=010, OR=011, SRL=100, SRA=101), and the FSM state constants EMPTY/FULL.
- Sub-module: instantiate the existing alu unchanged. The arbiter logic (grant, prio, response register, counter) stays in alu_share_arb.

Test Plan:
- Reset: rst_n=0 mid-FULL, asynchronously -> rsp_valid=0, rsp_data=0, done_cnt=0 without a clock edge; after release, first contested grant goes to req0.
- Single request: req0 a=5, b=3, op=000, rsp_ready=1 -> req0_ready=1 in cycle N; cycle N+1 rsp_valid=1, rsp_data=8, rsp_id=0; done_cnt=1 after the consume edge.
- Contention round-robin: both valid every cycle, req0 op=000 (1+1), req1 op=001 (10-4), rsp_ready=1 -> grants alternate 0,1,0,1; rsp_data sequence 2,6,2,6; rsp_id 0,1,0,1.
- Backpressure: rsp_ready=0 for 3 cycles with both valid -> readys 0, rsp_data stable; rsp_ready=1 -> consume and refill in the same cycle, and done_cnt increments by 1.
- Wrap: a=32'hFFFFFFFF, b=1, op=000 -> rsp_data=0. Preload done_cnt to 16'hFFFF via 65535 consumes -> next consume gives done_cnt=0.
- Idle consume: rsp_ready=1 while EMPTY -> done_cnt unchanged, no readys asserted.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared types for the alu sharing arbiter.
// ALUOp encodings and response register states.
package alu_share_arb_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SRL = 3'b100,
        OP_SRA = 3'b101
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Shared 32-bit combinational alu.
// Unused opcodes produce zero.
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] c
);

    // opcode decode; shift amount is the low five bits of b
    always_comb begin
        c = '0;
        case (alu_op)
            OP_ADD: c = a + b;
            OP_SUB: c = a - b;
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_SRL: c = a >> b[4:0];
            OP_SRA: c = $unsigned($signed(a) >>> b[4:0]);
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one alu between two requesters.
// Results land in a single-entry response register tagged by id.
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] done_cnt
);

    import alu_share_arb_pkg::*;

    rsp_state_e       state;
    logic             prio;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             acc0;
    logic             acc1;
    logic             consume;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_c;

    assign can_accept = (state == EMPTY) | rsp_ready;

    // contested requests go to the prio side
    assign grant0 = req0_valid & (~req1_valid | ~prio);
    assign grant1 = req1_valid & (~req0_valid | prio);

    assign req0_ready = can_accept & grant0;
    assign req1_ready = can_accept & grant1;

    assign acc0    = req0_valid & req0_ready;
    assign acc1    = req1_valid & req1_ready;
    assign consume = (state == FULL) & rsp_ready;

    assign rsp_valid = (state == FULL);

    // route the granted payload to the alu, zero when idle
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        unique case (1'b1)
            grant0: begin
                alu_a  = req0_a;
                alu_b  = req0_b;
                alu_op = req0_op;
            end
            grant1: begin
                alu_a  = req1_a;
                alu_b  = req1_b;
                alu_op = req1_op;
            end
            default: ;
        endcase
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .c      (alu_c)
    );

    // response register FSM, priority pointer and consume counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            prio     <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (consume) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (acc0 | acc1) begin
                        state    <= FULL;
                        rsp_data <= alu_c;
                        rsp_id   <= acc1;
                        prio     <= ~acc1;
                    end
                end
                FULL: begin
                    if (acc0 | acc1) begin
                        rsp_data <= alu_c;
                        rsp_id   <= acc1;
                        prio     <= ~acc1;
                    end else if (rsp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: spec-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;
    logic        req1_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_ready;
    logic [15:0] done_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .done_cnt   (done_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> sh;
            3'd5: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // behavioural model state
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic [15:0] m_cnt;
    logic        m_prio;
    logic        e_r0;
    logic        e_r1;
    logic        nx_valid;
    logic [31:0] nx_data;
    logic        nx_id;
    logic [15:0] nx_cnt;
    logic        nx_prio;

    task automatic m_reset();
        m_valid = 1'b0;
        m_data  = 32'd0;
        m_id    = 1'b0;
        m_cnt   = 16'd0;
        m_prio  = 1'b0;
    endtask

    // model + per-cycle compare
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_reset();
                continue;
            end
            e_r0 = (!m_valid || rsp_ready) && req0_valid
                   && (!req1_valid || !m_prio);
            e_r1 = (!m_valid || rsp_ready) && req1_valid
                   && (!req0_valid || m_prio);
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("m_rsp_data", rsp_data, m_data);
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_done_cnt", 32'(done_cnt), 32'(m_cnt));
            chk("m_req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("m_req1_ready", 32'(req1_ready), 32'(e_r1));
            nx_valid = m_valid;
            nx_data  = m_data;
            nx_id    = m_id;
            nx_prio  = m_prio;
            nx_cnt   = (m_valid && rsp_ready) ? m_cnt + 16'd1 : m_cnt;
            if (e_r0) begin
                nx_valid = 1'b1;
                nx_data  = alu_ref(req0_op, req0_a, req0_b);
                nx_id    = 1'b0;
                nx_prio  = 1'b1;
            end else if (e_r1) begin
                nx_valid = 1'b1;
                nx_data  = alu_ref(req1_op, req1_a, req1_b);
                nx_id    = 1'b1;
                nx_prio  = 1'b0;
            end else if (m_valid && rsp_ready) begin
                nx_valid = 1'b0;
            end
            @(posedge clk);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_valid = nx_valid;
                m_data  = nx_data;
                m_id    = nx_id;
                m_cnt   = nx_cnt;
                m_prio  = nx_prio;
            end
        end
    end

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic t0;
    logic t1;
    bit   hit;

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req0_op    = '0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_op    = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_cnt", 32'(done_cnt), 0);

        // single request 5+3
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_a     = 32'd5;
        req0_b     = 32'd3;
        req0_op    = 3'b000;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk("single_r0", 32'(req0_ready), 1);
        chk("single_r1", 32'(req1_ready), 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_data", rsp_data, 8);
        chk("single_id", 32'(rsp_id), 0);
        @(negedge clk);
        chk("single_cnt", 32'(done_cnt), 1);
        chk("single_empty", 32'(rsp_valid), 0);

        // fill, then reset asynchronously while FULL
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_a     = 32'd7;
        req0_b     = 32'd9;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        #1;
        chk("full_data", rsp_data, 16);
        chk("full_valid", 32'(rsp_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 0);
        chk("arst_data", rsp_data, 0);
        chk("arst_id", 32'(rsp_id), 0);
        chk("arst_cnt", 32'(done_cnt), 0);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // contention: 1+1 vs 10-4
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_a     = 32'd1;
        req0_b     = 32'd1;
        req0_op    = 3'b000;
        req1_valid = 1'b1;
        req1_a     = 32'd10;
        req1_b     = 32'd4;
        req1_op    = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("rr_r0", 32'(req0_ready), 32'(i % 2 == 0));
                chk("rr_r1", 32'(req1_ready), 32'(i % 2 == 1));
            end
            if (i > 0) begin
                chk("rr_data", rsp_data, ((i - 1) % 2 == 0) ? 2 : 6);
                chk("rr_id", 32'(rsp_id), 32'((i - 1) % 2));
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end

        // backpressure
        @(posedge clk);
        #1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'd100;
        req0_b     = 32'd23;
        req0_op    = 3'b001;
        req1_valid = 1'b1;
        req1_a     = 32'hF0;
        req1_b     = 32'h3C;
        req1_op    = 3'b010;
        @(negedge clk);
        chk("bp_first_r0", 32'(req0_ready), 1);
        chk("bp_cnt0", 32'(done_cnt), 4);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_r0", 32'(req0_ready), 0);
            chk("bp_r1", 32'(req1_ready), 0);
            chk("bp_data", rsp_data, 77);
            chk("bp_id", 32'(rsp_id), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_refill_r1", 32'(req1_ready), 1);
        chk("bp_cnt_pre", 32'(done_cnt), 4);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_cnt_post", 32'(done_cnt), 5);
        chk("bp_data2", rsp_data, 32'h30);
        chk("bp_id2", 32'(rsp_id), 1);
        chk("bp_valid2", 32'(rsp_valid), 1);

        // data wrap, then run the counter to its wrap
        @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_a     = 32'hFFFF_FFFF;
        req0_b     = 32'd1;
        req0_op    = 3'b000;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_data", rsp_data, 0);
        hit = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (m_cnt == 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
        end
        chk("cnt_reach_timeout", 32'(hit), 1);
        chk("cnt_ffff", 32'(done_cnt), 32'hFFFF);
        chk("cnt_ffff_valid", 32'(rsp_valid), 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("cnt_wrap0", 32'(done_cnt), 0);
        chk("cnt_wrap_valid", 32'(rsp_valid), 1);
        @(negedge clk);
        chk("cnt_one", 32'(done_cnt), 1);
        chk("cnt_one_empty", 32'(rsp_valid), 0);

        // rsp_ready while EMPTY
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_cnt", 32'(done_cnt), 1);
            chk("idle_r0", 32'(req0_ready), 0);
            chk("idle_r1", 32'(req1_ready), 0);
        end

        // random traffic obeying hold-until-ready
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            t0 = req0_valid & req0_ready;
            t1 = req1_valid & req1_ready;
            @(posedge clk);
            #1;
            if (t0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a     = rnd_word();
                req0_b     = rnd_word();
                req0_op    = 3'($urandom_range(0, 7));
            end
            if (t1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a     = rnd_word();
                req1_b     = rnd_word();
                req1_op    = 3'($urandom_range(0, 7));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
